// File: rtl/disp_sr_multi.sv
// disp_sr_multi: multi-chain serial display shifter with latch strobe and a one-deep frame queue
module disp_sr_multi #(
  parameter int WIDTH     = 256,
  parameter int CHAINS    = 2,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit LAT_POL   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic                      start,
  input  logic [WIDTH*CHAINS-1:0]   data,
  output logic                      busy,
  output logic                      done,
  output logic                      ovr,
  output logic                      disp_sclk,
  output logic                      disp_lat,
  output logic [CHAINS-1:0]         disp_sin
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SHIFT, S_END} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic ph, pend, sclk_r, lat_r, end_tick;
  logic [WIDTH*CHAINS-1:0] work, shadow;
  logic [CHAINS-1:0] sin_r, nxt;
  assign end_tick = (state == S_END) && tick;
  // next state: only tick edges advance, except leaving IDLE on start
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  state_nx = start ? S_LATCH : S_IDLE;
      S_LATCH: state_nx = (tick && ph) ? S_SHIFT : S_LATCH;
      S_SHIFT: state_nx = (tick && ph && cnt == LAST) ? S_END : S_SHIFT;
      S_END:   state_nx = !tick ? S_END : (pend || start) ? S_LATCH : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
  // bit presented on each chain for the current counter value
  always_comb begin
    nxt = '0;
    for (int c = 0; c < CHAINS; c++)
      nxt[c] = work[c*WIDTH + (LSB_FIRST ? int'(cnt) : WIDTH - 1 - int'(cnt))];
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  // frame datapath, queueing and internal display levels
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      ph <= 1'b0;
      pend <= 1'b0;
      work <= '0;
      shadow <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ovr <= 1'b0;
      sclk_r <= 1'b0;
      lat_r <= !LAT_POL;
      sin_r <= '0;
    end else begin
      done <= 1'b0;
      ovr <= 1'b0;
      if (state == S_IDLE) begin
        if (start) begin
          work <= data;
          busy <= 1'b1;
          cnt <= '0;
          ph <= 1'b0;
        end
      end else if (end_tick) begin
        done <= 1'b1;
        sclk_r <= 1'b0;
        sin_r <= '0;
        busy <= pend || start;
        pend <= 1'b0;
        ovr <= pend && start;
        work <= start ? data : shadow;
        cnt <= '0;
        ph <= 1'b0;
      end else begin
        if (start) begin
          shadow <= data;
          pend <= 1'b1;
          ovr <= pend;
        end
        if (tick && state == S_LATCH) begin
          lat_r <= ph ? !LAT_POL : LAT_POL;
          ph <= !ph;
          cnt <= '0;
        end else if (tick && state == S_SHIFT) begin
          ph <= !ph;
          sclk_r <= ph;
          if (!ph) sin_r <= nxt;
          else if (cnt != LAST) cnt <= cnt + 1'b1;
        end
      end
    end
  // extra output stage on the display pins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      disp_sclk <= 1'b0;
      disp_lat <= !LAT_POL;
      disp_sin <= '0;
    end else begin
      disp_sclk <= sclk_r;
      disp_lat <= lat_r;
      disp_sin <= sin_r;
    end
endmodule

// File: tb/tb_disp_sr_multi.sv
// tb_disp_sr_multi: directed plus random frames on three configurations against a serial-order model
module tb_disp_sr_multi;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, start_a = 1'b0, start_c = 1'b0;
  logic [15:0] data_a = '0;
  logic [255:0] data_c = '0;
  logic [2:0] busy, done, ovr, sclk, lat;
  logic [1:0] sin_a, sin_b;
  logic sin_c;
  localparam logic [2:0] POL = 3'b011;

  disp_sr_multi #(.WIDTH(8), .CHAINS(2), .LSB_FIRST(1'b0), .LAT_POL(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start_a), .data(data_a), .busy(busy[0]),
    .done(done[0]), .ovr(ovr[0]), .disp_sclk(sclk[0]), .disp_lat(lat[0]), .disp_sin(sin_a));
  disp_sr_multi #(.WIDTH(8), .CHAINS(2), .LSB_FIRST(1'b1), .LAT_POL(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start_a), .data(data_a), .busy(busy[1]),
    .done(done[1]), .ovr(ovr[1]), .disp_sclk(sclk[1]), .disp_lat(lat[1]), .disp_sin(sin_b));
  disp_sr_multi #(.WIDTH(256), .CHAINS(1), .LSB_FIRST(1'b0), .LAT_POL(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start_c), .data(data_c), .busy(busy[2]),
    .done(done[2]), .ovr(ovr[2]), .disp_sclk(sclk[2]), .disp_lat(lat[2]), .disp_sin(sin_c));

  always #5 clk = ~clk;

  int tp = 4, tcnt = 0;
  initial forever begin
    @(negedge clk);
    tcnt = (tcnt + 1 >= tp) ? 0 : tcnt + 1;
    tick = (tcnt == 0);
  end

  typedef struct {logic [255:0] c0, c1; int nb, latw, latn;} frame_t;
  frame_t fq[3][$];
  frame_t cur[3];
  int done_n[3] = '{0, 0, 0}, ovr_n[3] = '{0, 0, 0}, bfall[3] = '{0, 0, 0};
  logic [2:0] psclk = '0, pbusy = '0, plat = 3'b100;
  logic [1:0] ms;

  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      ms = i == 0 ? sin_a : i == 1 ? sin_b : {1'b0, sin_c};
      if (!rst_n) begin
        cur[i] = '{default: 0};
        psclk[i] = 1'b0;
        pbusy[i] = 1'b0;
        plat[i] = ~POL[i];
      end else begin
        if (sclk[i] && !psclk[i]) begin
          cur[i].c0 = {cur[i].c0[254:0], ms[0]};
          cur[i].c1 = {cur[i].c1[254:0], ms[1]};
          cur[i].nb++;
        end
        if (lat[i] == POL[i]) begin
          cur[i].latw++;
          if (plat[i] != POL[i]) cur[i].latn++;
        end
        if (ovr[i]) ovr_n[i]++;
        if (pbusy[i] && !busy[i]) bfall[i]++;
        if (done[i]) begin
          done_n[i]++;
          fq[i].push_back(cur[i]);
          cur[i] = '{default: 0};
        end
        psclk[i] = sclk[i];
        pbusy[i] = busy[i];
        plat[i] = lat[i];
      end
    end

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] ser(input logic [255:0] v, input int w, input bit lsb);
    logic [255:0] r = '0;
    for (int k = 0; k < w; k++) r = {r[254:0], lsb ? v[k] : v[w-1-k]};
    return r;
  endfunction

  task automatic wait_frames(input int i, input int n, input int budget);
    for (int k = 0; k < budget && fq[i].size() < n; k++) @(posedge clk);
    chk("frame_timeout", 256'(fq[i].size() >= n), 256'd1);
  endtask

  task automatic chk_frame(input int i, input string tag, input logic [255:0] d, input int w,
                           input bit lsb, input int latw);
    frame_t f;
    if (fq[i].size() == 0) begin
      chk({tag, "_missing"}, 256'd0, 256'd1);
      return;
    end
    f = fq[i].pop_front();
    chk({tag, "_bits"}, 256'(f.nb), 256'(w));
    chk({tag, "_c0"}, f.c0, ser(d, w, lsb));
    chk({tag, "_c1"}, f.c1, ser(d >> w, w, lsb));
    chk({tag, "_latn"}, 256'(f.latn), 256'd1);
    chk({tag, "_latw"}, 256'(f.latw), 256'(latw));
  endtask

  task automatic go_a(input logic [15:0] d);
    @(negedge clk);
    data_a = d;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    data_a = 16'($urandom);
  endtask

  task automatic idle_chk(input string tag);
    chk(tag, 256'({sclk, lat, busy, done, ovr, sin_a, sin_b, sin_c}), 256'({3'b000, 3'b100, 9'd0, 5'd0}));
  endtask

  initial begin
    logic [15:0] d;
    logic [255:0] dc;
    int o0, b0, d0;
    repeat (3) @(negedge clk);
    idle_chk("reset_idle");
    rst_n = 1'b1;
    go_a(16'h3CA5);
    chk("busy_after_start", 256'(busy[1:0]), 256'd3);
    wait_frames(0, 1, 400);
    wait_frames(1, 1, 400);
    chk_frame(0, "msb_3ca5", 256'h3CA5, 8, 1'b0, 4);
    chk_frame(1, "lsb_3ca5", 256'h3CA5, 8, 1'b1, 4);
    chk("busy_low_after", 256'(busy[1:0]), 256'd0);
    go_a(16'h0001);
    wait_frames(1, 1, 400);
    wait_frames(0, 1, 400);
    chk_frame(1, "lsb_0001", 256'h0001, 8, 1'b1, 4);
    chk_frame(0, "msb_0001", 256'h0001, 8, 1'b0, 4);
    for (int r = 0; r < 6; r++) begin
      tp = int'($urandom_range(1, 4));
      d = 16'($urandom);
      go_a(d);
      wait_frames(0, 1, 500);
      wait_frames(1, 1, 500);
      chk_frame(0, "rnd_msb", 256'(d), 8, 1'b0, tp);
      chk_frame(1, "rnd_lsb", 256'(d), 8, 1'b1, tp);
    end
    tp = 4;
    repeat (4) @(negedge clk);
    o0 = ovr_n[0]; b0 = bfall[0]; d0 = done_n[0];
    go_a(16'h00FF);
    repeat (10) @(negedge clk);
    go_a(16'h0F0F);
    repeat (10) @(negedge clk);
    go_a(16'hF0F0);
    wait_frames(0, 2, 800);
    wait_frames(1, 2, 800);
    chk_frame(0, "ovl_first", 256'h00FF, 8, 1'b0, 4);
    chk_frame(0, "ovl_second", 256'hF0F0, 8, 1'b0, 4);
    chk_frame(1, "ovl_first_lsb", 256'h00FF, 8, 1'b1, 4);
    chk_frame(1, "ovl_second_lsb", 256'hF0F0, 8, 1'b1, 4);
    chk("ovl_ovr_count", 256'(ovr_n[0] - o0), 256'd1);
    chk("ovl_busy_falls", 256'(bfall[0] - b0), 256'd1);
    chk("ovl_done_count", 256'(done_n[0] - d0), 256'd2);
    tp = 1;
    repeat (2) @(negedge clk);
    o0 = ovr_n[0]; b0 = bfall[0]; d0 = done_n[0];
    data_a = 16'h1234;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (18) @(negedge clk);
    data_a = 16'hBEEF;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_frames(0, 2, 200);
    chk_frame(0, "endedge_first", 256'h1234, 8, 1'b0, 1);
    chk_frame(0, "endedge_second", 256'hBEEF, 8, 1'b0, 1);
    wait_frames(1, 2, 200);
    void'(fq[1].pop_front());
    void'(fq[1].pop_front());
    chk("endedge_busy_falls", 256'(bfall[0] - b0), 256'd1);
    chk("endedge_done_count", 256'(done_n[0] - d0), 256'd2);
    chk("endedge_no_ovr", 256'(ovr_n[0] - o0), 256'd0);
    tp = 4;
    repeat (4) @(negedge clk);
    d0 = done_n[0];
    go_a(16'h5A3C);
    repeat (38) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 idle_chk("midframe_reset_idle");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("midframe_no_done", 256'(done_n[0] - d0), 256'd0);
    chk("midframe_no_frame", 256'(fq[0].size()), 256'd0);
    d = 16'($urandom);
    go_a(d);
    wait_frames(0, 1, 500);
    wait_frames(1, 1, 500);
    chk_frame(0, "after_reset", 256'(d), 8, 1'b0, 4);
    chk_frame(1, "after_reset_lsb", 256'(d), 8, 1'b1, 4);
    tp = 1;
    for (int k = 0; k < 8; k++) dc[k*32 +: 32] = $urandom;
    @(negedge clk);
    data_c = dc;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    data_c = '0;
    wait_frames(2, 1, 1000);
    chk_frame(2, "w256_pol0", dc, 256, 1'b0, 1);
    @(negedge clk);
    chk("w256_lat_idle_high", 256'(lat[2]), 256'd1);
    chk("w256_done_count", 256'(done_n[2]), 256'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/disp_sr_multi.md
DISP_SR_MULTI -- requirements
Module: disp_sr_multi

Interface
REQ-001 Parameter WIDTH, default 256: bits per chain, minimum 2.
REQ-002 Parameter CHAINS, default 2: parallel serial chains sharing sclk and lat, minimum 1.
REQ-003 Parameter LSB_FIRST, default 0: 0 = bit WIDTH-1 shifted first; 1 = bit 0 shifted first.
REQ-004 Parameter LAT_POL, default 1: active level of disp_lat.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 clk  input  1  clock.
REQ-007 tick  input  1  half-bit-period enable, one clk wide; all shifting and latch timing advances only on clk edges where tick=1.
REQ-008 start  input  1  frame request, one clk wide.
REQ-009 data  input  WIDTH*CHAINS  frame data; chain c occupies data[c*WIDTH +: WIDTH], sampled on the start edge only.
REQ-010 busy  output  1  high from the edge after an accepted start until the done edge.
REQ-011 done  output  1  one-clk pulse at frame end.
REQ-012 ovr  output  1  one-clk pulse when a start overwrites an already pending frame.
REQ-013 disp_sclk  output  1  shared shift clock.
REQ-014 disp_lat  output  1  shared latch strobe.
REQ-015 disp_sin  output  CHAINS  serial data, bit c drives chain c.

Function
REQ-016 FSM states are IDLE, LATCH, SHIFT and END; FSM transitions occur only on tick edges, except the IDLE -> LATCH transition.
REQ-017 IDLE with start=1: load data into the working shift registers, set busy, enter LATCH; a tick on the same edge is not counted.
REQ-018 LATCH timing: first tick drives lat active; the following tick drives lat inactive and enters SHIFT with bit counter 0 and phase 0; the latch pulse lasts exactly one tick period.
REQ-019 SHIFT phase 0, on tick: sclk low; sin[c] = next bit of chain c, MSB-first or LSB-first per LSB_FIRST; phase becomes 1.
REQ-020 SHIFT phase 1, on tick: sclk high with sin held; counter increments and phase becomes 0.
REQ-021 After phase 1 of bit WIDTH-1, enter END; a frame is exactly 2*WIDTH SHIFT ticks.
REQ-022 END, on tick: sclk low, sin 0, done=1 for one clk, busy low.
REQ-023 END without a pending frame: go to IDLE.
REQ-024 END with a pending frame: load the shadow register into the working registers, clear pending, keep busy high on the next clk, and enter LATCH.
REQ-025 start while busy: capture data into the shadow register (WIDTH*CHAINS) and set pending; the frame in progress is undisturbed.
REQ-026 start while already pending: overwrite the shadow register (latest wins) and pulse ovr.
REQ-027 start on the same edge as the END tick: treated as a pending start, so that frame follows back-to-back.
REQ-028 Bit counter width is $clog2(WIDTH); the counter never wraps within a frame and is cleared on entering LATCH.
REQ-029 disp_sclk, disp_lat and disp_sin are registered, then pass through one further output flop stage; they lag internal state by exactly one clk.
REQ-030 busy, done and ovr are registered with no extra output stage.
REQ-031 Idle levels: disp_sclk 0, disp_lat !LAT_POL, disp_sin all 0.

Reset
REQ-032 rst_n low asynchronously forces state IDLE, counter 0, phase 0, pending 0, working and shadow registers 0.
REQ-033 rst_n low forces busy 0, done 0, ovr 0, disp_sclk 0, disp_lat !LAT_POL and disp_sin 0, including both output stages.
REQ-034 Reset mid-frame abandons the frame, with no done pulse; after reset release the block waits for a new start.

Verification
REQ-035 WIDTH=8, CHAINS=2, tick every 4 clk; start with data 0x3CA5 -> one lat pulse of 4 clk, then 8 sclk rising edges; sin[0] = 1,0,1,0,0,1,0,1 and sin[1] = 0,0,1,1,1,1,0,0, each sampled at sclk rise; then done pulses once.
REQ-036 Same bench with LSB_FIRST=1 and data 0x3CA5 -> sin[0] = 1,0,1,0,0,1,0,1 (0xA5 is bit-symmetric); sin[1] = 0,0,1,1,1,1,0,0; verify the LSB-first order with 0x0001 -> sin[0] = 1 on the first bit only.
REQ-037 start 0x00FF, then start 0x0F0F mid-frame, then start 0xF0F0 mid-frame -> ovr pulses once; the second frame shifts 0xF0F0 back-to-back after done; busy stays high across the boundary.
REQ-038 start on the same edge as the END tick -> done pulses, busy does not drop, and the next LATCH begins on the next tick.
REQ-039 rst_n asserted at bit 3 of a frame -> all outputs reach idle levels immediately; no done pulse; a fresh start afterwards produces a correct full frame.
REQ-040 LAT_POL=0, WIDTH=256, CHAINS=1 -> disp_lat idles high and pulses low; exactly 256 sclk rises between the latch pulse and done.
